// File: rtl/alu_driver.sv
// alu_driver: command front-end for a combinational N-bit ALU
// (opcodes 00 add, 01 sub, 10 and, 11 or).
//
// The block accepts a command over cmd_valid/cmd_ready and registers the
// operands and opcode onto the ALU inputs. It waits SETTLE cycles, captures
// alu_out, and then presents the result over rsp_valid/rsp_ready.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_opnd1/cmd_opnd2/cmd_op      command payload
//   alu_opnd1/alu_opnd2/alu_operation  registered ALU inputs
//   alu_out                         ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_result/rsp_op               captured result and its opcode
//   busy                            high in WAIT or RESP
//   done_count                      completed response handshakes (wraps)
module alu_driver #(
    parameter int N      = 8,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_opnd1,
    input  logic [N-1:0]     cmd_opnd2,
    input  logic [1:0]       cmd_op,
    output logic [N-1:0]     alu_opnd1,
    output logic [N-1:0]     alu_opnd2,
    output logic [1:0]       alu_operation,
    input  logic [N-1:0]     alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic [1:0]       rsp_op,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_chk
        $error("alu_driver: SETTLE must be in 1..15");
    end

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    logic            rdy_q;
    logic [N-1:0]    opnd1_nx, opnd2_nx, res_nx;
    logic [1:0]      op_nx, rop_nx;
    logic [CNT_W-1:0] done_nx;

    // rdy_q holds cmd_ready low during reset and sets on the first edge
    // after release. This keeps cmd_ready a pure register decode with no
    // combinational path from rst.
    assign cmd_ready = (state == IDLE) && rdy_q;
    assign rsp_valid = (state == RESP);
    assign busy      = (state == WAIT) || (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rdy_q         <= 1'b0;
            alu_opnd1     <= '0;
            alu_opnd2     <= '0;
            alu_operation <= '0;
            rsp_result    <= '0;
            rsp_op        <= '0;
            done_count    <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            rdy_q         <= 1'b1;
            alu_opnd1     <= opnd1_nx;
            alu_opnd2     <= opnd2_nx;
            alu_operation <= op_nx;
            rsp_result    <= res_nx;
            rsp_op        <= rop_nx;
            done_count    <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        opnd1_nx = alu_opnd1;
        opnd2_nx = alu_opnd2;
        op_nx    = alu_operation;
        res_nx   = rsp_result;
        rop_nx   = rsp_op;
        done_nx  = done_count;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    opnd1_nx = cmd_opnd1;
                    opnd2_nx = cmd_opnd2;
                    op_nx    = cmd_op;
                    cnt_nx   = SETTLE_M1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // The count reaches zero SETTLE-1 edges after the accept.
                // Capture therefore lands on edge T+SETTLE.
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    res_nx   = alu_out;
                    rop_nx   = alu_operation;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    done_nx  = done_count + CNT_W'(1);
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_driver.sv
module tb_alu_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    function automatic logic [7:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
        case (op)
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return x & y;
            default: return x | y;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---- DUT A: SETTLE=2, combinational ALU ----
    logic a_cmd_valid = 0, a_cmd_ready, a_rsp_valid, a_rsp_ready = 0, a_busy;
    logic [7:0] a_opnd1 = 0, a_opnd2 = 0, a_alu_o1, a_alu_o2, a_alu_out, a_rsp_result;
    logic [1:0] a_op = 0, a_alu_op, a_rsp_op;
    logic [15:0] a_done;
    assign a_alu_out = alu_f(a_alu_o1, a_alu_o2, a_alu_op);

    alu_driver #(.N(8), .SETTLE(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_opnd1(a_opnd1), .cmd_opnd2(a_opnd2), .cmd_op(a_op),
        .alu_opnd1(a_alu_o1), .alu_opnd2(a_alu_o2), .alu_operation(a_alu_op),
        .alu_out(a_alu_out), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_result(a_rsp_result), .rsp_op(a_rsp_op), .busy(a_busy), .done_count(a_done));

    // ---- DUT B: SETTLE=1, CNT_W=2, combinational ALU ----
    logic b_cmd_valid = 0, b_cmd_ready, b_rsp_valid, b_rsp_ready = 0, b_busy;
    logic [7:0] b_alu_o1, b_alu_o2, b_alu_out, b_rsp_result;
    logic [1:0] b_alu_op, b_rsp_op, b_done;
    assign b_alu_out = alu_f(b_alu_o1, b_alu_o2, b_alu_op);

    alu_driver #(.N(8), .SETTLE(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_opnd1(8'h03), .cmd_opnd2(8'h04), .cmd_op(2'b00),
        .alu_opnd1(b_alu_o1), .alu_opnd2(b_alu_o2), .alu_operation(b_alu_op),
        .alu_out(b_alu_out), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_result(b_rsp_result), .rsp_op(b_rsp_op), .busy(b_busy), .done_count(b_done));

    // ---- DUTs C (SETTLE=2) and D (SETTLE=1): ALU output lags inputs by one cycle ----
    logic c_valid = 0, c_rsp_ready = 0;
    logic [7:0] c_o1 = 0, c_o2 = 0;
    logic [1:0] c_op = 0;
    logic c_cmd_ready, c_rsp_valid, c_busy, d_cmd_ready, d_rsp_valid, d_busy;
    logic [7:0] c_alu_o1, c_alu_o2, c_rsp_result, d_alu_o1, d_alu_o2, d_rsp_result;
    logic [1:0] c_alu_op, c_rsp_op, d_alu_op, d_rsp_op;
    logic [7:0] c_alu_dly, d_alu_dly;
    logic [15:0] c_done, d_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            c_alu_dly <= 8'h00;
            d_alu_dly <= 8'h00;
        end else begin
            c_alu_dly <= alu_f(c_alu_o1, c_alu_o2, c_alu_op);
            d_alu_dly <= alu_f(d_alu_o1, d_alu_o2, d_alu_op);
        end
    end

    alu_driver #(.N(8), .SETTLE(2), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .cmd_valid(c_valid), .cmd_ready(c_cmd_ready),
        .cmd_opnd1(c_o1), .cmd_opnd2(c_o2), .cmd_op(c_op),
        .alu_opnd1(c_alu_o1), .alu_opnd2(c_alu_o2), .alu_operation(c_alu_op),
        .alu_out(c_alu_dly), .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
        .rsp_result(c_rsp_result), .rsp_op(c_rsp_op), .busy(c_busy), .done_count(c_done));

    alu_driver #(.N(8), .SETTLE(1), .CNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .cmd_valid(c_valid), .cmd_ready(d_cmd_ready),
        .cmd_opnd1(c_o1), .cmd_opnd2(c_o2), .cmd_op(c_op),
        .alu_opnd1(d_alu_o1), .alu_opnd2(d_alu_o2), .alu_operation(d_alu_op),
        .alu_out(d_alu_dly), .rsp_valid(d_rsp_valid), .rsp_ready(c_rsp_ready),
        .rsp_result(d_rsp_result), .rsp_op(d_rsp_op), .busy(d_busy), .done_count(d_done));

    // One full transaction on DUT A with cycle-exact checks (SETTLE=2).
    task automatic run_a(input string nm, input logic [1:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] r);
        logic [15:0] d0;
        d0 = a_done;
        @(negedge clk);
        a_cmd_valid = 1; a_opnd1 = x; a_opnd2 = y; a_op = op; a_rsp_ready = 0;
        chk({nm, ".ready"}, a_cmd_ready, 1);
        @(negedge clk);                         // after accept edge T
        a_cmd_valid = 0;
        chk({nm, ".busy"}, a_busy, 1);
        chk({nm, ".alu_o1"}, a_alu_o1, x);
        chk({nm, ".alu_o2"}, a_alu_o2, y);
        chk({nm, ".alu_op"}, a_alu_op, op);
        chk({nm, ".vld_t0"}, a_rsp_valid, 0);
        @(negedge clk);                         // after T+1
        chk({nm, ".vld_t1"}, a_rsp_valid, 0);
        @(negedge clk);                         // after T+2
        chk({nm, ".vld_t2"}, a_rsp_valid, 1);
        chk({nm, ".result"}, a_rsp_result, r);
        chk({nm, ".rsp_op"}, a_rsp_op, op);
        a_rsp_ready = 1;
        @(negedge clk);                         // after handshake edge T+3
        a_rsp_ready = 0;
        chk({nm, ".vld_done"}, a_rsp_valid, 0);
        chk({nm, ".done"}, a_done, d0 + 16'd1);
        chk({nm, ".idle_ready"}, a_cmd_ready, 1);
        chk({nm, ".alu_hold"}, a_alu_o1, x);
    endtask

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, acc9, t[3];
        logic stray;

        vecs[0] = '{"add_7f_01", 2'b00, 8'h7F, 8'h01, 8'h80};
        vecs[1] = '{"sub_00_01", 2'b01, 8'h00, 8'h01, 8'hFF};
        vecs[2] = '{"and_f0_3c", 2'b10, 8'hF0, 8'h3C, 8'h30};
        vecs[3] = '{"or_a0_05",  2'b11, 8'hA0, 8'h05, 8'hA5};
        vecs[4] = '{"add_carry", 2'b00, 8'hFF, 8'h01, 8'h00};
        vecs[5] = '{"sub_05_03", 2'b01, 8'h05, 8'h03, 8'h02};

        // Reset state while rst is asserted
        repeat (2) @(negedge clk);
        chk("rst.cmd_ready", a_cmd_ready, 0);
        chk("rst.rsp_valid", a_rsp_valid, 0);
        chk("rst.busy", a_busy, 0);
        chk("rst.done", a_done, 0);
        chk("rst.alu_o1", a_alu_o1, 0);
        chk("rst.rsp_result", a_rsp_result, 0);
        rst = 0;
        @(negedge clk);
        chk("rel.cmd_ready", a_cmd_ready, 1);

        // Directed vectors
        for (int i = 0; i < 6; i++)
            run_a(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
        chk("vec.done_total", a_done, 6);

        // Backpressure with new command data pushed during RESP
        @(negedge clk);
        a_cmd_valid = 1; a_opnd1 = 8'h11; a_opnd2 = 8'h22; a_op = 2'b00; a_rsp_ready = 0;
        @(negedge clk);
        a_cmd_valid = 1; a_opnd1 = 8'h55; a_opnd2 = 8'h66; a_op = 2'b11;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp.valid", a_rsp_valid, 1);
            chk("bp.result", a_rsp_result, 8'h33);
            chk("bp.cmd_ready", a_cmd_ready, 0);
            chk("bp.busy", a_busy, 1);
            chk("bp.alu_o1", a_alu_o1, 8'h11);
            chk("bp.alu_op", a_alu_op, 2'b00);
            @(negedge clk);
        end
        a_rsp_ready = 1; a_cmd_valid = 0;
        @(negedge clk);
        a_rsp_ready = 0;
        chk("bp.vld_drop", a_rsp_valid, 0);
        chk("bp.idle", a_cmd_ready, 1);
        chk("bp.busy_low", a_busy, 0);
        chk("bp.done", a_done, 7);

        // Throughput and counter wrap on DUT B (SETTLE=1, CNT_W=2)
        acc = 0; acc9 = 0; t[0] = 0; t[1] = 0; t[2] = 0;
        @(negedge clk);
        b_cmd_valid = 1; b_rsp_ready = 1;
        for (int k = 0; k < 15; k++) begin
            if (b_cmd_ready) begin
                if (acc < 3) t[acc] = k;
                acc++;
                if (k < 9) acc9++;
            end
            @(negedge clk);
        end
        b_cmd_valid = 0;
        chk("tp.accepts_9", acc9, 3);
        chk("tp.gap01", t[1] - t[0], 3);
        chk("tp.gap12", t[2] - t[1], 3);
        chk("tp.accepts_15", acc, 5);
        chk("tp.done_wrap", b_done, 1);
        chk("tp.result", b_rsp_result, 8'h07);

        // Sampling edge against a one-cycle-late ALU: C (SETTLE=2) vs D (SETTLE=1)
        @(negedge clk);
        c_valid = 1; c_o1 = 8'h10; c_o2 = 8'h20; c_op = 2'b00; c_rsp_ready = 1;
        @(negedge clk);
        c_valid = 0;
        repeat (4) @(negedge clk);
        chk("lag1.settle2", c_rsp_result, 8'h30);
        chk("lag1.settle1", d_rsp_result, 8'h00);
        c_valid = 1; c_o1 = 8'h50; c_o2 = 8'h08; c_op = 2'b01;
        @(negedge clk);
        c_valid = 0;
        repeat (4) @(negedge clk);
        chk("lag2.settle2", c_rsp_result, 8'h48);
        chk("lag2.settle1_stale", d_rsp_result, 8'h30);
        chk("lag2.c_done", c_done, 2);
        chk("lag2.d_done", d_done, 2);
        c_rsp_ready = 0;

        // Reset during WAIT
        @(negedge clk);
        a_cmd_valid = 1; a_opnd1 = 8'h12; a_opnd2 = 8'h34; a_op = 2'b11;
        @(negedge clk);
        a_cmd_valid = 0;
        a_rsp_ready = 1;
        #2 rst = 1;
        #1;
        chk("rw.rsp_valid", a_rsp_valid, 0);
        chk("rw.busy", a_busy, 0);
        chk("rw.cmd_ready", a_cmd_ready, 0);
        chk("rw.alu_o1", a_alu_o1, 0);
        chk("rw.alu_op", a_alu_op, 0);
        chk("rw.done", a_done, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rw.ready_after", a_cmd_ready, 1);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_rsp_valid) stray = 1;
        end
        chk("rw.no_response", stray, 0);
        a_rsp_ready = 0;

        // Reset during RESP, after one completed transaction
        run_a("pre_rr", 2'b10, 8'hCC, 8'h0F, 8'h0C);
        @(negedge clk);
        a_cmd_valid = 1; a_opnd1 = 8'h01; a_opnd2 = 8'h02; a_op = 2'b00;
        @(negedge clk);
        a_cmd_valid = 0;
        repeat (2) @(negedge clk);
        chk("rr.in_resp", a_rsp_valid, 1);
        #2 rst = 1;
        #1;
        chk("rr.rsp_valid", a_rsp_valid, 0);
        chk("rr.result", a_rsp_result, 0);
        chk("rr.rsp_op", a_rsp_op, 0);
        chk("rr.done", a_done, 0);
        chk("rr.alu_o2", a_alu_o2, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rr.ready_after", a_cmd_ready, 1);
        chk("rr.no_response", a_rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
